// File: rtl/mosby_pkg.sv
// Shared constants and types for the fetch unit and its prefetch queue.
package mosby_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] NOP = 8'hEA;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Fetch addresses wrap modulo 2^16.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: DEPTH entries of WIDTH bits with head/tail pointers and occupancy.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk_2,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_2) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_2) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Byte prefetcher: one outstanding memory read feeding a DEPTH-entry queue toward the decoder.
// Optional FETCH_BYPASS_EN forwards an ack straight to the decoder when the queue is empty.
module fetch_unit
    import mosby_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk_2,
    input  logic               rst,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               mem_ack,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic [DATA_W-1:0]  instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  instr_pc,
    output fetch_state_t       state
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  fpc;
    logic               discard;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_after;
    logic [ENTRY_W-1:0] head_raw;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic               q_empty;
    logic               ack_live;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               can_issue;

    assign head       = fetch_entry_t'(head_raw);
    assign push_entry = '{data: mem_data, addr: mem_addr};
    assign q_empty    = (count == '0);

    // An ack is only useful if it answers a live request that no flush has orphaned.
    assign ack_live = (state == BUSY) && mem_ack && !discard && !flush;

`ifdef FETCH_BYPASS_EN
    assign bypass = q_empty && ack_live;

    always_comb begin
        instr_valid = !q_empty || bypass;
        instruction = NOP;
        instr_pc    = fpc;
        if (!q_empty) begin
            instruction = head.data;
            instr_pc    = head.addr;
        end else if (bypass) begin
            instruction = mem_data;
            instr_pc    = mem_addr;
        end
    end
`else
    assign bypass = 1'b0;

    always_comb begin
        instr_valid = !q_empty;
        instruction = NOP;
        instr_pc    = fpc;
        if (!q_empty) begin
            instruction = head.data;
            instr_pc    = head.addr;
        end
    end
`endif

    // A bypassed byte that the decoder takes immediately never enters the queue.
    assign push = ack_live && !(bypass && instr_ready);
    assign pop  = !q_empty && instr_ready && !flush;

    assign count_after = count + CW'(push) - CW'(pop);
    assign can_issue   = (count_after < CW'(DEPTH));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_2     (clk_2),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .count     (count)
    );

    always_ff @(posedge clk_2) begin
        if (!rst) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= RESET_PC;
            fpc      <= RESET_PC;
            discard  <= 1'b0;
        end else if (flush) begin
            fpc <= flush_addr;
            // The bus cannot be cancelled: wait out the old request and drop its data.
            if (state == BUSY && !mem_ack) begin
                discard <= 1'b1;
            end else begin
                state   <= IDLE;
                mem_rd  <= 1'b0;
                discard <= 1'b0;
            end
        end else if (state == IDLE || mem_ack) begin
            discard <= 1'b0;
            if (can_issue) begin
                state    <= BUSY;
                mem_rd   <= 1'b1;
                mem_addr <= fpc;
                fpc      <= next_pc(fpc);
            end else begin
                state  <= IDLE;
                mem_rd <= 1'b0;
            end
        end
    end

endmodule
